// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding,
// default counter width and enable/flush polarity constants.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HAZ      = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 2;

  // Write-enable polarity: RUN lets a register load, STOP holds it.
  localparam logic RUN  = 1'b1;
  localparam logic STOP = 1'b0;

  // Flush/bubble polarity.
  localparam logic INJ_ON  = 1'b1;
  localparam logic INJ_OFF = 1'b0;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
// Only built with PIPE_STALL_PERF_EN, the only configuration that uses it.
`ifdef PIPE_STALL_PERF_EN
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                         r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Pipeline freeze/flush controller: hazard countdown, MDU wait and redirects.
// Optional stall performance counters with PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef PIPE_STALL_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic [CNT_W-1:0] stall_cycles,
  input  logic             branch_taken,
  input  logic             exc_req,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_wena,
  output logic             if_id_wena,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             id_exe_wena,
  output logic             exe_mem_bubble,
  output logic             stall_active
`ifdef PIPE_STALL_PERF_EN
  , output logic [PERF_W-1:0] perf_stall_cnt
  , output logic [PERF_W-1:0] perf_mdu_cnt
`endif
);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_haz_len;
  logic             r_exc_pend, w_pend_nxt;
  logic             w_exc, w_haz_frz, w_mdu_frz, w_br;

  // A request of N cycles spends its first cycle in RUN, the rest in HAZ.
  assign w_haz_len = (stall_cycles == '0) ? '0 : stall_cycles - 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_exc_pend;
    w_exc       = 1'b0;
    w_haz_frz   = 1'b0;
    w_mdu_frz   = 1'b0;
    w_br        = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          if (exc_req || r_exc_pend) begin
            w_exc      = 1'b1;
            w_pend_nxt = 1'b0;
          end else if (mdu_start) begin
            w_mdu_frz   = 1'b1;
            w_state_nxt = ST_MDU_WAIT;
          end else if (stall_req) begin
            w_haz_frz = 1'b1;
            w_cnt_nxt = w_haz_len;
            if (w_haz_len != '0) w_state_nxt = ST_HAZ;
          end else if (branch_taken) begin
            w_br = 1'b1;
          end
        end
        ST_HAZ: begin
          if (exc_req) begin
            w_exc       = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUN;
          end else begin
            w_haz_frz = 1'b1;
            if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt <= CNT_W'(1)) w_state_nxt = ST_RUN;
          end
        end
        ST_MDU_WAIT: begin
          // Redirects are held until the MDU releases the pipe.
          w_mdu_frz = 1'b1;
          if (exc_req)  w_pend_nxt  = 1'b1;
          if (mdu_done) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_wena        = RUN;
    if_id_wena     = RUN;
    id_exe_wena    = RUN;
    if_id_flush    = INJ_OFF;
    id_exe_bubble  = INJ_OFF;
    exe_mem_bubble = INJ_OFF;
    if (w_exc) begin
      if_id_flush   = INJ_ON;
      id_exe_bubble = INJ_ON;
    end
    if (w_br) if_id_flush = INJ_ON;
    if (w_haz_frz) begin
      pc_wena       = STOP;
      if_id_wena    = STOP;
      id_exe_bubble = INJ_ON;
    end
    if (w_mdu_frz) begin
      pc_wena        = STOP;
      if_id_wena     = STOP;
      id_exe_wena    = STOP;
      exe_mem_bubble = INJ_ON;
    end
    if (rst) begin
      pc_wena     = STOP;
      if_id_wena  = STOP;
      id_exe_wena = STOP;
    end
    stall_active = w_haz_frz | w_mdu_frz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_exc_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_exc_pend <= w_pend_nxt;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  sat_counter #(.W(PERF_W)) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_haz_frz),
    .o_cnt (perf_stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_perf_mdu (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_mdu_frz),
    .o_cnt (perf_mdu_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of freezes and redirects.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst, stall_req, branch_taken, exc_req, mdu_start, mdu_done;
  logic [1:0] stall_cycles;
  logic       pc_wena, if_id_wena, if_id_flush, id_exe_bubble;
  logic       id_exe_wena, exe_mem_bubble, stall_active;
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_mdu_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req      (stall_req),
    .stall_cycles   (stall_cycles),
    .branch_taken   (branch_taken),
    .exc_req        (exc_req),
    .mdu_start      (mdu_start),
    .mdu_done       (mdu_done),
    .pc_wena        (pc_wena),
    .if_id_wena     (if_id_wena),
    .if_id_flush    (if_id_flush),
    .id_exe_bubble  (id_exe_bubble),
    .id_exe_wena    (id_exe_wena),
    .exe_mem_bubble (exe_mem_bubble),
    .stall_active   (stall_active)
`ifdef PIPE_STALL_PERF_EN
    , .perf_stall_cnt (perf_stall_cnt)
    , .perf_mdu_cnt   (perf_mdu_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state: cycles of hazard freeze still owed after the current one,
  // whether the MDU holds the pipe, and a deferred exception.
  int          m_haz_left = 0;
  bit          m_mdu_busy = 0;
  bit          m_pend     = 0;
  logic [31:0] m_perf_haz = 0, m_perf_mdu = 0;

  // Output vector order: {pc, if_id_wena, flush, id_exe_bubble, id_exe_wena, exe_mem_bubble, stall_active}
  localparam logic [6:0] O_RST  = 7'b0000000;
  localparam logic [6:0] O_IDLE = 7'b1100100;
  localparam logic [6:0] O_EXC  = 7'b1111100;
  localparam logic [6:0] O_HAZ  = 7'b0001101;
  localparam logic [6:0] O_MDU  = 7'b0000011;
  localparam logic [6:0] O_BR   = 7'b1110100;

  logic [6:0] last_o;
  int         sa_seen, mb_seen;

  task automatic cyc(input string tag, input logic r, input logic s, input logic [1:0] sc,
                     input logic b, input logic e, input logic ms, input logic md);
    logic [6:0] exp_o;
    int         len;
    rst = r; stall_req = s; stall_cycles = sc; branch_taken = b;
    exc_req = e; mdu_start = ms; mdu_done = md;
    #4;
    exp_o = O_IDLE;
    if (r) begin
      exp_o = O_RST;
    end else if (m_mdu_busy) begin
      exp_o = O_MDU;
      if (e)  m_pend = 1;
      if (md) m_mdu_busy = 0;
    end else if (m_haz_left > 0) begin
      if (e) begin
        exp_o = O_EXC;
        m_haz_left = 0;
      end else begin
        exp_o = O_HAZ;
        m_haz_left--;
      end
    end else if (e || m_pend) begin
      exp_o  = O_EXC;
      m_pend = 0;
    end else if (ms) begin
      exp_o      = O_MDU;
      m_mdu_busy = 1;
    end else if (s) begin
      exp_o      = O_HAZ;
      len        = (sc == 0) ? 1 : int'(sc);
      m_haz_left = len - 1;
    end else if (b) begin
      exp_o = O_BR;
    end
    last_o = {pc_wena, if_id_wena, if_id_flush, id_exe_bubble, id_exe_wena, exe_mem_bubble, stall_active};
    chk(tag, 32'(last_o), 32'(exp_o));
    if (stall_active)   sa_seen++;
    if (exe_mem_bubble) mb_seen++;
`ifdef PIPE_STALL_PERF_EN
    chk({tag, "_perf_haz"}, perf_stall_cnt, m_perf_haz);
    chk({tag, "_perf_mdu"}, perf_mdu_cnt, m_perf_mdu);
`endif
    if (r) begin
      m_haz_left = 0; m_mdu_busy = 0; m_pend = 0;
      m_perf_haz = 0; m_perf_mdu = 0;
    end else begin
      if (exp_o == O_HAZ && m_perf_haz != '1) m_perf_haz++;
      if (exp_o == O_MDU && m_perf_mdu != '1) m_perf_mdu++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 2'd0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc("rst0", 1, 0, 2'd0, 0, 0, 0, 0);
    cyc("rst1", 1, 1, 2'd2, 1, 1, 1, 1);
    chk("rst_outs", 32'(last_o), 32'(O_RST));
    idle("idle0");
    chk("idle_outs", 32'(last_o), 32'(O_IDLE));

    // two-cycle hazard freeze
    cyc("haz2_c1", 0, 1, 2'd2, 0, 0, 0, 0);
    chk("haz2_c1_pc", 32'(last_o[6]), 0);
    idle("haz2_c2");
    chk("haz2_c2_bub", 32'(last_o[3]), 1);
    idle("haz2_c3");
    chk("haz2_c3_pc", 32'(last_o[6]), 1);

    // stall_cycles=0 behaves as 1
    cyc("haz0_c1", 0, 1, 2'd0, 0, 0, 0, 0);
    idle("haz0_c2");
    chk("haz0_resume", 32'(last_o), 32'(O_IDLE));

    // 34-cycle MDU freeze
    sa_seen = 0; mb_seen = 0;
    cyc("mdu_start", 0, 0, 2'd0, 0, 0, 1, 0);
    for (int i = 0; i < 32; i++) idle("mdu_wait");
    cyc("mdu_done", 0, 0, 2'd0, 0, 0, 0, 1);
    chk("mdu_len", sa_seen, 34);
    chk("mdu_bubbles", mb_seen, 34);
    idle("mdu_after");
    chk("mdu_after_en", 32'(last_o), 32'(O_IDLE));

    // exception deferred during MDU wait
    cyc("mdx_start", 0, 0, 2'd0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle("mdx_wait");
    cyc("mdx_exc", 0, 0, 2'd0, 1, 1, 0, 0);
    chk("mdx_no_flush", 32'(last_o[4]), 0);
    for (int i = 0; i < 3; i++) idle("mdx_wait2");
    cyc("mdx_done", 0, 0, 2'd0, 0, 0, 0, 1);
    idle("mdx_flush");
    chk("mdx_flush_outs", 32'(last_o), 32'(O_EXC));
    idle("mdx_cleared");
    chk("mdx_pend_clr", 32'(last_o), 32'(O_IDLE));

    // exception beats stall; branch ignored inside HAZ
    cyc("exc_vs_stall", 0, 1, 2'd2, 0, 1, 0, 0);
    chk("exc_vs_stall_pc", 32'(last_o[6]), 1);
    cyc("haz3_c1", 0, 1, 2'd3, 0, 0, 0, 0);
    cyc("haz3_br", 0, 0, 2'd0, 1, 0, 0, 0);
    chk("haz_br_ignored", 32'(last_o[4]), 0);
    idle("haz3_c3");
    idle("haz3_out");
    chk("haz3_resume", 32'(last_o), 32'(O_IDLE));

    // exception aborts HAZ
    cyc("haza_c1", 0, 1, 2'd3, 0, 0, 0, 0);
    cyc("haza_exc", 0, 0, 2'd0, 0, 1, 0, 0);
    idle("haza_after");
    chk("haza_resume", 32'(last_o), 32'(O_IDLE));

    // reset in the middle of a hazard freeze
    cyc("hazr_c1", 0, 1, 2'd2, 0, 0, 0, 0);
    cyc("hazr_rst", 1, 0, 2'd0, 0, 0, 0, 0);
    idle("hazr_after");
    chk("hazr_resume", 32'(last_o), 32'(O_IDLE));
`ifdef PIPE_STALL_PERF_EN
    chk("hazr_perf_zero", perf_stall_cnt, 0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc("rand", ($urandom_range(63) == 0), ($urandom_range(3) == 0),
          2'($urandom_range(3)), ($urandom_range(3) == 0), ($urandom_range(15) == 0),
          ($urandom_range(15) == 0), ($urandom_range(7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline control block that consumes the ID-stage hazard stall requests, the multiply/divide unit busy handshake, and the branch/exception redirects. It turns them into per-stage write enables, bubbles and flushes for the PC, IF/ID, ID/EXE and EXE/MEM registers. It sits between the hazard detector and the pipeline registers of the 54-instruction MIPS pipeline, and it owns every multi-cycle freeze in the core.

## Interface
Parameters:
- `CNT_W`, default 2: width of the hazard countdown counter.
- `PERF_W`, default 32: width of the performance counters (used only with `PIPE_STALL_PERF_EN`).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_req`  in  1  hazard detector requests a freeze of IF/ID.
- `stall_cycles`  in  `CNT_W`  total freeze length in cycles (1 = MEM hazard, 2 = EXE hazard); 0 is treated as 1.
- `branch_taken`  in  1  ID resolved a taken branch/jump; squash the IF/ID contents.
- `exc_req`  in  1  exception or ERET redirect from EXE; squash the younger stages.
- `mdu_start`  in  1  EXE launched a multi-cycle MULT/DIV.
- `mdu_done`  in  1  MDU result is ready, one-cycle pulse.
- `pc_wena`  out  1  PC register write enable.
- `if_id_wena`  out  1  IF/ID register write enable.
- `if_id_flush`  out  1  IF/ID loads a NOP.
- `id_exe_bubble`  out  1  ID/EXE loads a NOP.
- `id_exe_wena`  out  1  ID/EXE register write enable.
- `exe_mem_bubble`  out  1  EXE/MEM loads a NOP.
- `stall_active`  out  1  high in every cycle the PC is frozen.
- `perf_stall_cnt`, `perf_mdu_cnt`  out  `PERF_W`  stall-cycle counters; present only with the macro.

## Operation
- State machine: RUN, HAZ, MDU_WAIT. Registered state: `state`, `cnt` (`CNT_W`), `exc_pend`.
- Outputs are Mealy, combinational from state and inputs. A freeze takes effect in the same cycle it is requested.
- Default in RUN with no event: all wena=1, all flush/bubble=0, `stall_active`=0.
- Priority in RUN, highest first: `exc_req` > `mdu_start` > `stall_req` > `branch_taken`.
- RUN with `exc_req`:
  - Outputs: `if_id_flush`=1, `id_exe_bubble`=1, `pc_wena`=1.
  - Next state: RUN.
- RUN with `mdu_start`:
  - Outputs: `pc_wena`=`if_id_wena`=`id_exe_wena`=0, `exe_mem_bubble`=1.
  - Next state: MDU_WAIT.
- RUN with `stall_req`:
  - Outputs: `pc_wena`=`if_id_wena`=0, `id_exe_bubble`=1.
  - `cnt` ← max(`stall_cycles`,1)−1.
  - Next state: HAZ if that value is nonzero, else RUN.
- RUN with `branch_taken` only: `if_id_flush`=1.
- HAZ:
  - Outputs: same as the RUN `stall_req` case. `stall_req` and `branch_taken` are ignored.
  - `cnt` decrements each cycle; the cycle in which `cnt`==1 is the last HAZ cycle, then next state RUN.
  - `exc_req` in HAZ aborts: exception outputs as in RUN, `cnt`←0, next state RUN.
- MDU_WAIT:
  - Outputs: same as the RUN `mdu_start` case.
  - `exc_req` sets `exc_pend` instead of flushing.
  - `mdu_done` → next state RUN. Both `mdu_start` and `mdu_done` high in one cycle: `mdu_done` wins, no re-entry.
- First RUN cycle after MDU_WAIT with `exc_pend`=1: exception outputs as in RUN, then `exc_pend` is cleared.
- Invariant: `pc_wena`==`if_id_wena` whenever `if_id_flush`=0.

## Timing
- Reset (`rst`=1 at an edge):
  - Next cycle: state=RUN, `cnt`=0, `exc_pend`=0.
  - Outputs while `rst` is high: every wena=0, every flush/bubble=0, `stall_active`=0, perf counters→0.
  - Reset mid-HAZ or mid-MDU_WAIT abandons the freeze with no pending effect.
- Hazard freeze length equals `stall_cycles` exactly: 2 → PC frozen for 2 consecutive cycles, resumes on the 3rd.
- MDU freeze: frozen from the `mdu_start` cycle through the `mdu_done` cycle inclusive; enables are 1 in the cycle after `mdu_done`.
- `cnt` never wraps: decrement occurs only in HAZ with `cnt`≥1.

## Configuration
- `PIPE_STALL_PERF_EN` defined:
  - `perf_stall_cnt` increments in each cycle with HAZ-type freeze.
  - `perf_mdu_cnt` increments in each MDU_WAIT-type freeze cycle.
  - Both saturate at all-ones; both clear on `rst`.
- Undefined: ports and counters are absent; no other behaviour changes.

## Structure
- Shared package/header: state encodings (`ST_RUN`, `ST_HAZ`, `ST_MDU_WAIT`), `CNT_W` default, and the existing `RUN`/`STOP` and enable-polarity constants.
- Natural sub-module: `sat_counter` (width-parameterised, saturating, sync clear), instantiated twice under the macro.

## Test plan
- `stall_req`=1, `stall_cycles`=2 in RUN → `pc_wena`=0 for exactly 2 cycles, `id_exe_bubble`=1 both cycles, `pc_wena`=1 on cycle 3.
- `stall_req`=1, `stall_cycles`=0 → one-cycle freeze, state stays RUN.
- `mdu_start` pulse, `mdu_done` 33 cycles later → `stall_active`=1 for 34 cycles, `exe_mem_bubble`=1 throughout.
- `exc_req` during MDU_WAIT cycle 5 → no flush until exit; first RUN cycle shows `if_id_flush`=`id_exe_bubble`=1, then `exc_pend`=0.
- `exc_req` and `stall_req` together in RUN → flush outputs with `pc_wena`=1; `branch_taken` during HAZ → ignored, `if_id_flush`=0.
- `rst` asserted mid-HAZ (`cnt`=1) → next cycle state=RUN, all enables 1 after release; with macro, `perf_stall_cnt`=0.
